// File: rtl/lfsr_index_finder.sv
// Finds the position of a 4-bit value in the x^4+x^3+1 LFSR sequence that starts at SEED.
// It does this by stepping a local LFSR from SEED until it equals the requested value or the period runs out.
module lfsr_index_finder #(
    parameter logic [3:0] SEED = 4'b0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [3:0] lfsr_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] index_out,
    output logic       found,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'd14;
    localparam logic [3:0] NOT_FOUND  = 4'hF;

    state_t     state;
    state_t     state_next;
    logic [3:0] target;
    logic [3:0] target_next;
    logic [3:0] walker;
    logic [3:0] walker_next;
    logic [3:0] count;
    logic [3:0] count_next;
    logic [3:0] index_next;
    logic       found_next;

    function automatic logic [3:0] lfsr_step(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            target    <= 4'd0;
            walker    <= SEED;
            count     <= 4'd0;
            index_out <= 4'd0;
            found     <= 1'b0;
        end else begin
            state     <= state_next;
            target    <= target_next;
            walker    <= walker_next;
            count     <= count_next;
            index_out <= index_next;
            found     <= found_next;
        end
    end

    // The match test comes before the end-of-period test, so the value at index 14 is still reported as found.
    always_comb begin
        state_next  = state;
        target_next = target;
        walker_next = walker;
        count_next  = count;
        index_next  = index_out;
        found_next  = found;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next  = SEARCH;
                    target_next = lfsr_in;
                    walker_next = SEED;
                    count_next  = 4'd0;
                    index_next  = 4'd0;
                    found_next  = 1'b0;
                end
            end
            SEARCH: begin
                if (walker == target) begin
                    state_next = DONE;
                    index_next = count;
                    found_next = 1'b1;
                end else if (count == LAST_INDEX) begin
                    state_next = DONE;
                    index_next = NOT_FOUND;
                    found_next = 1'b0;
                end else begin
                    walker_next = lfsr_step(walker);
                    count_next  = count + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (clr) begin
            state_next  = IDLE;
            walker_next = SEED;
            count_next  = 4'd0;
            index_next  = 4'd0;
            found_next  = 1'b0;
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SEARCH);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_lfsr_index_finder.sv
// Self-checking bench for lfsr_index_finder: directed scenarios plus randomized requests,
// with expectations taken from the published index table of the SEED=0001 sequence.
module tb_lfsr_index_finder;

    logic       clk;
    logic       reset;
    logic       clr;
    logic [3:0] lfsr_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] index_out;
    logic       found;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int total;
    int bad;

    logic [3:0] seq_table [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                                   4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                                   4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    lfsr_index_finder #(.SEED(4'b0001)) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .lfsr_in  (lfsr_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .index_out(index_out),
        .found    (found),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Position of v in the table, or 15 when the value never appears.
    function automatic int model_index(input logic [3:0] v);
        for (int i = 0; i < 15; i++) begin
            if (seq_table[i] == v) return i;
        end
        return 15;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic startRequest(input logic [3:0] v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_request", int'(in_ready), 1);
        in_valid = 1'b1;
        lfsr_in  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lfsr_in  = 4'($urandom);
    endtask

    // Called 1 time unit after the accept edge; counts edges until the result appears.
    task automatic awaitResult(input logic [3:0] v);
        int edges;
        int idx;
        idx   = model_index(v);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            lfsr_in = 4'($urandom);
        end while (!out_valid && edges < 20);
        checkOutput($sformatf("latency_%b", v), edges, (idx == 15) ? 15 : idx + 1);
        checkOutput($sformatf("index_%b", v), int'(index_out), idx);
        checkOutput($sformatf("found_%b", v), int'(found), (idx == 15) ? 0 : 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("consume_out_valid", int'(out_valid), 0);
        checkOutput("consume_in_ready", int'(in_ready), 1);
    endtask

    // Full transaction: request, result check, stall with stray input pulses, then consume.
    task automatic applyStimulus(input logic [3:0] v, input int stall);
        int idx;
        idx = model_index(v);
        startRequest(v);
        awaitResult(v);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            lfsr_in  = 4'($urandom);
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", int'(out_valid), 1);
            checkOutput("hold_index", int'(index_out), idx);
            checkOutput("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        consume();
    endtask

    initial begin
        int idx;
        int seen;
        logic [3:0] order [16];
        logic [3:0] tmp;

        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        clr       = 1'b0;
        lfsr_in   = 4'd0;
        in_valid  = 1'b1;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_index", int'(index_out), 0);
        checkOutput("reset_found", int'(found), 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(4'b0001, 0);
        applyStimulus(4'b1010, 0);
        applyStimulus(4'b1000, 0);
        applyStimulus(4'b0000, 0);
        applyStimulus(4'b0101, 5);

        // A request presented on the consume edge must wait one more edge.
        startRequest(4'b1001);
        awaitResult(4'b1001);
        in_valid  = 1'b1;
        lfsr_in   = 4'b0010;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("no_accept_on_consume_ready", int'(in_ready), 1);
        checkOutput("no_accept_on_consume_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("accept_after_consume_busy", int'(busy), 1);
        awaitResult(4'b0010);
        consume();

        startRequest(4'b1000);
        checkOutput("search_busy", int'(busy), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_in_ready", int'(in_ready), 1);
        checkOutput("clr_busy", int'(busy), 0);
        checkOutput("clr_index", int'(index_out), 0);
        seen = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        checkOutput("clr_no_result", seen, 0);
        applyStimulus(4'b0100, 0);

        startRequest(4'b0011);
        awaitResult(4'b0011);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_out_valid", int'(out_valid), 0);
        checkOutput("async_reset_in_ready", int'(in_ready), 1);
        checkOutput("async_reset_index", int'(index_out), 0);
        checkOutput("async_reset_found", int'(found), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) order[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            idx        = int'($urandom_range(0, i));
            tmp        = order[i];
            order[i]   = order[idx];
            order[idx] = tmp;
        end
        for (int i = 0; i < 16; i++) applyStimulus(order[i], 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_index_finder.md
LFSR_INDEX_FINDER -- requirements
Module: lfsr_index_finder

Interface
REQ-001 SHALL have parameter SEED, default 4'b0001: LFSR state at index 0; must be nonzero.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port clr, input, 1 bit: synchronous abort; returns the FSM to IDLE.
REQ-005 SHALL have port lfsr_in, input, 4 bits: LFSR value whose sequence index is requested.
REQ-006 SHALL have port in_valid, input, 1 bit: lfsr_in is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-008 SHALL have port index_out, output, 4 bits: sequence index of the accepted value.
REQ-009 SHALL have port found, output, 1 bit: value occurs in the LFSR sequence.
REQ-010 SHALL have port out_valid, output, 1 bit: index_out and found are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port busy, output, 1 bit: search in progress.

Function
REQ-013 SHALL use the reference LFSR step next = {q[2:0], q[3]^q[2]} (x^4+x^3+1, period 15); index 0 = SEED.
REQ-014 SHALL, with SEED=0001, map 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000 to indices 0..14.
REQ-015 SHALL implement FSM states IDLE, SEARCH, DONE; in_ready=1 only in IDLE; busy=1 only in SEARCH; out_valid=1 only in DONE.
REQ-016 SHALL accept a request on a clk edge with in_valid&&in_ready: capture lfsr_in as target, load walker=SEED, step count=0, go to SEARCH.
REQ-017 SHALL, each SEARCH cycle: if walker==target -> index_out=count, found=1, go to DONE; else if count==14 -> index_out=4'hF, found=0, go to DONE; else walker=step(walker), count=count+1.
REQ-018 SHALL produce out_valid exactly k+1 edges after the accept edge for a value at index k (0..14), and 15 edges after it for a value not in the sequence (0000).
REQ-019 SHALL hold index_out, found, and out_valid stable in DONE until out_valid&&out_ready; on that edge go to IDLE and clear out_valid.
REQ-020 SHALL NOT accept a new request in the same edge a result is consumed; the next accept occurs no earlier than the following edge.
REQ-021 SHALL, when clr=1 on an edge, go to IDLE from any state, clear out_valid/found/busy, set index_out=0, and discard the pending request or result; clr has priority over accept and out_ready.
REQ-022 SHALL ignore lfsr_in and in_valid outside IDLE; the captured target is unaffected by later lfsr_in changes.
REQ-023 SHALL keep count 4 bits wide; count never exceeds 14 (no wrap).

Reset
REQ-024 SHALL, while reset=1, asynchronously force FSM=IDLE, index_out=0, found=0, out_valid=0, busy=0, walker=SEED, count=0; in_ready=1 (IDLE); no transfer is accepted while reset=1.
REQ-025 SHALL abandon any SEARCH or DONE state on reset assertion mid-operation; after release the first accepted request behaves per REQ-016.

Verification
REQ-026 SHALL cover: reset release, lfsr_in=0001 accepted -> 1 edge later out_valid=1, index_out=0, found=1.
REQ-027 SHALL cover: lfsr_in=1010 -> out_valid 8 edges after accept, index_out=7, found=1; lfsr_in=1000 -> 15 edges, index_out=14.
REQ-028 SHALL cover: lfsr_in=0000 -> out_valid 15 edges after accept, index_out=4'hF, found=0.
REQ-029 SHALL cover: out_ready=0 for 5 cycles in DONE -> outputs held; in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-030 SHALL cover: clr asserted mid-SEARCH (lfsr_in=1000, 3 edges after accept) -> IDLE next edge, no out_valid; new request 0100 -> index_out=2.
REQ-031 SHALL cover: reset asserted between clock edges in DONE -> out_valid=0 immediately, without waiting for a clock edge; exhaustive sweep of all 16 inputs matches REQ-014.
